// File: rtl/imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe
//
// Pipelined immediate extender for the ID/EX boundary. An IN_W-bit immediate
// is extended to OUT_W bits according to ExtMode at enqueue time, then held
// in a 2-entry valid/ready skid buffer so EX-stage stalls never drop an
// operand. Flush squashes all buffered and incoming entries.
//
// Ports:
//   CLK        in   1      clock, rising edge
//   Reset      in   1      synchronous, active-high reset
//   InValid    in   1      upstream presents an immediate
//   InReady    out  1      buffer can accept (depends on state only)
//   ExtMode    in   2      00 zero-ext, 01 sign-ext, 10 upper, 11 sext << SHAMT
//   Immediate  in   IN_W   raw immediate field
//   Flush      in   1      discard buffered and same-cycle incoming entries
//   OutValid   out  1      Out holds a valid operand
//   OutReady   in   1      downstream takes Out this cycle
//   Out        out  OUT_W  operand at buffer head, zero when empty
//   ExtCount   out  16     accepted-push counter (only with IMM_EXT_CNT_EN)
//
// Build option:
//   IMM_EXT_CNT_EN  adds ExtCount, a wrapping 16-bit count of accepted pushes
//                   (flushed pushes included), cleared only by Reset.
// ---------------------------------------------------------------------------
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [1:0]       ExtMode,
  input  logic [IN_W-1:0]  Immediate,
  input  logic             Flush,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [OUT_W-1:0] Out
`ifdef IMM_EXT_CNT_EN
  ,
  output logic [15:0]      ExtCount
`endif
);

  localparam int E = OUT_W - IN_W;

  // The encoding doubles as the occupancy count (0, 1 or 2 entries).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [OUT_W-1:0]   r_head;
  logic [OUT_W-1:0]   r_tail;

  logic               w_push;
  logic               w_pop;
  logic [IN_W-1:0]    w_imm;
  logic [1:0]         w_mode;
  logic [OUT_W-1:0]   w_sext;
  logic [OUT_W-1:0]   w_ext;

  assign w_push = InValid & InReady;
  assign w_pop  = OutValid & OutReady;

  // Gate the raw fields so an undriven immediate on idle cycles cannot push
  // X into the extender.
  assign w_imm  = InValid ? Immediate : '0;
  assign w_mode = InValid ? ExtMode   : 2'b00;

  // -------------------------------------------------------------------------
  // Extension function
  // -------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_sext = {{E{w_imm[IN_W-1]}}, w_imm};
    w_ext  = w_sext;
    case (w_mode)
      2'b00:   w_ext = {{E{1'b0}}, w_imm};
      2'b01:   w_ext = w_sext;
      2'b10:   w_ext = {w_imm, {E{1'b0}}};
      default: w_ext = w_sext << SHAMT;  // branch word offset, LSBs zero-fill
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_EMPTY: if (w_push) w_next_state = ST_ONE;
      ST_ONE: begin
        if (w_push && !w_pop)      w_next_state = ST_TWO;
        else if (w_pop && !w_push) w_next_state = ST_EMPTY;
      end
      ST_TWO:   if (w_pop) w_next_state = ST_ONE;
      default:  w_next_state = ST_EMPTY;
    endcase
    // Branch squash overrides every handshake outcome.
    if (Flush) w_next_state = ST_EMPTY;
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (functions of current state only)
  // -------------------------------------------------------------------------
  always_comb begin
    InReady  = (r_state != ST_TWO);
    OutValid = (r_state != ST_EMPTY);
    Out      = '0;
    if (r_state != ST_EMPTY) Out = r_head;
  end

  // -------------------------------------------------------------------------
  // Entry storage
  // -------------------------------------------------------------------------
  // NOTE: the two data entries are reset to zero so a fresh buffer never
  // carries stale operands; this costs only 2*OUT_W reset flops.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (!Flush) begin
      case (r_state)
        ST_EMPTY: if (w_push) r_head <= w_ext;
        ST_ONE: begin
          if (w_push && !w_pop)     r_tail <= w_ext;
          else if (w_push && w_pop) r_head <= w_ext;
        end
        ST_TWO:   if (w_pop) r_head <= r_tail;
        default: ;
      endcase
    end
  end

`ifdef IMM_EXT_CNT_EN
  // -------------------------------------------------------------------------
  // Accepted-push counter: Flush does not clear it, and a push that is
  // accepted then squashed still counts.
  // -------------------------------------------------------------------------
  logic [15:0] r_ext_count;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_ext_count <= '0;
    end else if (w_push) begin
      r_ext_count <= r_ext_count + 16'd1;
    end
  end

  assign ExtCount = r_ext_count;
`endif

endmodule
